// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory byte
// address, and captures PC/instruction into the IF/ID pipeline register under
// stall, flush and redirect control.
// Optional build macro FETCH_PERF_EN adds fetch/bubble event counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned SIZE_ADDRESS = 10,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stall_i,
    input  logic                    flush_i,
    input  logic                    redirect_valid_i,
    input  logic [31:0]             redirect_target_i,
    output logic [SIZE_ADDRESS-1:0] imem_address_o,
    input  logic [31:0]             imem_instruction_i,
    output logic [31:0]             pc_o,
    output logic                    ifid_valid_o,
    output logic [31:0]             ifid_pc_o,
    output logic [31:0]             ifid_pc_plus4_o,
    output logic [31:0]             ifid_instruction_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]             fetch_count_o,
    output logic [31:0]             bubble_count_o
`endif
);

    typedef enum logic [1:0] {StRun, StHold, StKill} fetch_state_e;

    fetch_state_e state_q, state_d;

    logic [31:0] pc_q, pc_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    // Next PC: redirect beats stall; targets are forced word-aligned.
    always_comb begin
        pc_d = pc_plus4;
        if (redirect_valid_i) begin
            pc_d = redirect_target_i & 32'hFFFF_FFFC;
        end else if (stall_i) begin
            pc_d = pc_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: the state names what IF/ID does on this edge.
    always_comb begin
        state_d = StRun;
        if (redirect_valid_i || flush_i) begin
            state_d = StKill;
        end else if (stall_i) begin
            state_d = StHold;
        end
    end

    // FSM outputs: IF/ID next values decoded from the state being entered.
    always_comb begin
        ifid_valid_d    = ifid_valid_q;
        ifid_pc_d       = ifid_pc_q;
        ifid_pc_plus4_d = ifid_pc_plus4_q;
        ifid_instr_d    = ifid_instr_q;
        unique case (state_d)
            StKill: begin
                ifid_valid_d    = 1'b0;
                ifid_pc_d       = 32'd0;
                ifid_pc_plus4_d = 32'd0;
                ifid_instr_d    = NOP_INSTR;
            end
            StHold: begin
                // A hold right after a kill keeps the bubble invalid.
                ifid_valid_d = (state_q == StKill) ? 1'b0 : ifid_valid_q;
            end
            StRun: begin
                ifid_valid_d    = 1'b1;
                ifid_pc_d       = pc_q;
                ifid_pc_plus4_d = pc_plus4;
                ifid_instr_d    = imem_instruction_i;
            end
            default: begin
                ifid_valid_d = ifid_valid_q;
            end
        endcase
    end

    // PC and IF/ID pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q            <= RESET_PC;
            ifid_valid_q    <= 1'b0;
            ifid_pc_q       <= 32'd0;
            ifid_pc_plus4_q <= 32'd0;
            ifid_instr_q    <= NOP_INSTR;
        end else begin
            pc_q            <= pc_d;
            ifid_valid_q    <= ifid_valid_d;
            ifid_pc_q       <= ifid_pc_d;
            ifid_pc_plus4_q <= ifid_pc_plus4_d;
            ifid_instr_q    <= ifid_instr_d;
        end
    end

    assign imem_address_o     = pc_q[SIZE_ADDRESS-1:0];
    assign pc_o               = pc_q;
    assign ifid_valid_o       = ifid_valid_q;
    assign ifid_pc_o          = ifid_pc_q;
    assign ifid_pc_plus4_o    = ifid_pc_plus4_q;
    assign ifid_instruction_o = ifid_instr_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] bubble_count_q, bubble_count_d;

    // Counters: one per valid load, one per inserted bubble; both wrap.
    always_comb begin
        fetch_count_d  = fetch_count_q;
        bubble_count_d = bubble_count_q;
        if (state_d == StRun) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
        if (state_d == StKill) begin
            bubble_count_d = bubble_count_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_q  <= 32'd0;
            bubble_count_q <= 32'd0;
        end else begin
            fetch_count_q  <= fetch_count_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign fetch_count_o  = fetch_count_q;
    assign bubble_count_o = bubble_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a combinational
// instruction-memory model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        flush_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_target_i;
    logic [9:0]  imem_address_o;
    logic [31:0] imem_instruction_i;
    logic [31:0] pc_o;
    logic        ifid_valid_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_pc_plus4_o;
    logic [31:0] ifid_instruction_o;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_o;
    logic [31:0] bubble_count_o;
`endif

    logic [31:0] mem [256];
    int n_checks;
    int n_fails;

    fetch_stage #(
        .RESET_PC     (32'h0000_0000),
        .SIZE_ADDRESS (10),
        .NOP_INSTR    (NOP)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .stall_i            (stall_i),
        .flush_i            (flush_i),
        .redirect_valid_i   (redirect_valid_i),
        .redirect_target_i  (redirect_target_i),
        .imem_address_o     (imem_address_o),
        .imem_instruction_i (imem_instruction_i),
        .pc_o               (pc_o),
        .ifid_valid_o       (ifid_valid_o),
        .ifid_pc_o          (ifid_pc_o),
        .ifid_pc_plus4_o    (ifid_pc_plus4_o),
        .ifid_instruction_o (ifid_instruction_o)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count_o      (fetch_count_o),
        .bubble_count_o     (bubble_count_o)
`endif
    );

    assign imem_instruction_i = mem[imem_address_o[9:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic v, input logic [31:0] pc,
                              input logic [31:0] pc4, input logic [31:0] instr);
        check({tag, ".valid"}, {31'd0, ifid_valid_o}, {31'd0, v});
        check({tag, ".pc"}, ifid_pc_o, pc);
        check({tag, ".pc4"}, ifid_pc_plus4_o, pc4);
        check({tag, ".instr"}, ifid_instruction_o, instr);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00A0_0113;

        rst_n = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_target_i = 32'd0;

        #12;
        check("rst.pc", pc_o, 32'h0);
        check_ifid("rst", 1'b0, 32'h0, 32'h0, NOP);
`ifdef FETCH_PERF_EN
        check("rst.fcnt", fetch_count_o, 32'd0);
        check("rst.bcnt", bubble_count_o, 32'd0);
`endif
        rst_n = 1'b1;

        step();
        check_ifid("e1", 1'b1, 32'h0, 32'h4, 32'h0050_0093);
        check("e1.pc", pc_o, 32'h4);
        step();
        check_ifid("e2", 1'b1, 32'h4, 32'h8, 32'h00A0_0113);
        check("e2.pc", pc_o, 32'h8);
        check("e2.addr", {22'd0, imem_address_o}, 32'h8);

        // Three stalled cycles at pc=8.
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall.pc", pc_o, 32'h8);
            check_ifid("stall", 1'b1, 32'h4, 32'h8, 32'h00A0_0113);
        end
        stall_i = 1'b0;
        step();
        check_ifid("unstall", 1'b1, 32'h8, 32'hC, 32'hA000_0002);
        check("unstall.pc", pc_o, 32'hC);

        // Redirect to a misaligned target; low bits cleared.
        redirect_valid_i = 1'b1;
        redirect_target_i = 32'h0000_0042;
        step();
        check("redir.pc", pc_o, 32'h40);
        check_ifid("redir", 1'b0, 32'h0, 32'h0, NOP);
        check("redir.addr", {22'd0, imem_address_o}, 32'h40);
        redirect_valid_i = 1'b0;
        step();
        check_ifid("redir2", 1'b1, 32'h40, 32'h44, 32'hA000_0010);
        check("redir2.pc", pc_o, 32'h44);

        // Get to pc=16, then stall+flush together.
        redirect_valid_i = 1'b1;
        redirect_target_i = 32'h0000_0010;
        step();
        check("to16.pc", pc_o, 32'h10);
        redirect_valid_i = 1'b0;
        stall_i = 1'b1;
        flush_i = 1'b1;
        step();
        check("sf.pc", pc_o, 32'h10);
        check_ifid("sf", 1'b0, 32'h0, 32'h0, NOP);
        stall_i = 1'b0;
        flush_i = 1'b0;
        step();
        check_ifid("sf2", 1'b1, 32'h10, 32'h14, 32'hA000_0004);
        check("sf2.pc", pc_o, 32'h14);

        // Flush alone advances the PC; a following stall keeps the bubble.
        flush_i = 1'b1;
        step();
        check("fl.pc", pc_o, 32'h18);
        check_ifid("fl", 1'b0, 32'h0, 32'h0, NOP);
        flush_i = 1'b0;
        stall_i = 1'b1;
        step();
        check("flst.pc", pc_o, 32'h18);
        check_ifid("flst", 1'b0, 32'h0, 32'h0, NOP);

        // Redirect beats stall; then wrap from the top of the address space.
        redirect_valid_i = 1'b1;
        redirect_target_i = 32'hFFFF_FFFE;
        step();
        check("top.pc", pc_o, 32'hFFFF_FFFC);
        check_ifid("top", 1'b0, 32'h0, 32'h0, NOP);
        redirect_valid_i = 1'b0;
        stall_i = 1'b0;
        step();
        check("wrap.pc", pc_o, 32'h0);
        check_ifid("wrap", 1'b1, 32'hFFFF_FFFC, 32'h0, 32'hA000_00FF);
`ifdef FETCH_PERF_EN
        check("pre.fcnt", fetch_count_o, 32'd6);
        check("pre.bcnt", bubble_count_o, 32'd5);
`endif

        // Asynchronous reset mid-cycle with stall high.
        step();
        stall_i = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.pc", pc_o, 32'h0);
        check_ifid("arst", 1'b0, 32'h0, 32'h0, NOP);
`ifdef FETCH_PERF_EN
        check("arst.fcnt", fetch_count_o, 32'd0);
        check("arst.bcnt", bubble_count_o, 32'd0);
`endif
        #10;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage sitting directly upstream of the instruction memory.
- Owns the program counter and drives the memory byte address; the memory returns the word combinationally.
- Captures PC and instruction into the IF/ID pipeline register, with stall, flush and redirect (branch/jump) control from the hazard and execute logic.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- SIZE_ADDRESS, 10, width of the instruction-memory byte address.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in IF/ID when invalid.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- stall_i  input  1  hold PC and IF/ID contents
- flush_i  input  1  insert bubble into IF/ID
- redirect_valid_i  input  1  take redirect_target_i as next PC
- redirect_target_i  input  32  branch/jump target byte address
- imem_address_o  output  SIZE_ADDRESS  byte address to instruction memory (= pc[SIZE_ADDRESS-1:0])
- imem_instruction_i  input  32  instruction word returned combinationally by memory
- pc_o  output  32  current fetch PC
- ifid_valid_o  output  1  IF/ID holds a real instruction
- ifid_pc_o  output  32  PC of the instruction in IF/ID
- ifid_pc_plus4_o  output  32  ifid_pc_o + 4
- ifid_instruction_o  output  32  instruction in IF/ID

Behaviour:
- Reset: asynchronous on rst_n low.
  - pc = RESET_PC
  - ifid_valid = 0
  - ifid_pc = 0
  - ifid_pc_plus4 = 0
  - ifid_instruction = NOP_INSTR
- Reset asserted mid-operation takes effect immediately; no state survives.
- imem_address_o is a combinational slice of pc; no internal memory latency is modelled.
- Latency: the instruction at PC X appears on ifid_* at the first rising edge after pc = X. The first valid instruction is visible one cycle after rst_n deasserts.
- Next-PC priority each edge (highest first):
  1. redirect_valid_i: pc <= {redirect_target_i[31:2], 2'b00}. Low bits are silently cleared.
  2. stall_i: pc holds.
  3. Otherwise: pc <= pc + 4, 32-bit modular; 32'hFFFF_FFFC wraps to 0.
- IF/ID update each edge (highest first):
  1. redirect_valid_i or flush_i: bubble. valid = 0, instruction = NOP_INSTR, pc and pc_plus4 = 0.
  2. stall_i: all IF/ID fields hold, including valid.
  3. Otherwise: valid = 1, pc = pc, pc_plus4 = pc + 4, instruction = imem_instruction_i.
- Simultaneous events:
  - Redirect and flush override stall.
  - flush without redirect and with stall: PC holds, IF/ID becomes a bubble.
- Internal fetch FSM:
  - States: RUN, HOLD, KILL. State resets to RUN.
  - KILL is entered on any cycle with redirect or flush.
  - HOLD is entered on stall with no redirect and no flush.
  - RUN is entered otherwise.
  - State is informational, used for ifid_valid bookkeeping and debug only. Outputs derive from the rules above.
- Address width: pc bits above SIZE_ADDRESS are not checked. Memory aliasing is the integrator's concern.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - Adds output fetch_count_o [31:0], reset to 0.
  - Increments by 1 on each edge where IF/ID loads a valid instruction (rule 3 of the IF/ID update).
  - Wraps at 2^32.
  - Adds output bubble_count_o [31:0], incremented on each edge where a flush or redirect bubble is inserted.
- Not defined: neither port nor either counter exists; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC=0, memory word0=32'h00500093, word1=32'h00A00113. Release rst_n.
  - Edge 1: ifid_instruction=32'h00500093, ifid_pc=0, ifid_pc_plus4=4, valid=1, pc_o=4.
  - Edge 2: instruction=32'h00A00113.
- At pc=8, assert stall_i for 3 cycles. pc_o stays 8 and ifid_* hold the PC=4 entry. After release, the next edge loads PC=8.
- At pc=12, assert redirect_valid_i with target 32'h0000_0042.
  - Next edge: pc_o=32'h40, valid=0, ifid_instruction=NOP_INSTR.
  - Following edge: ifid_pc=32'h40, valid=1.
- At pc=16, assert stall_i and flush_i together. pc_o stays 16, valid=0. Deassert both; the next edge loads PC=16 valid.
- Force pc to 32'hFFFF_FFFC via redirect. The next unstalled edge gives pc_o=0.
- Assert rst_n low mid-run with stall_i high. pc_o=RESET_PC and valid=0 immediately, without a clock edge. Under FETCH_PERF_EN both counters read 0.
